// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state enum, default geometry and address-field helpers
// for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    RESP
  } state_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 64;
  localparam int DEF_ADDR_W     = 32;

  function automatic int offset_w(int lw);
    return $clog2(lw);
  endfunction

  function automatic int index_w(int nl);
    return $clog2(nl);
  endfunction

  function automatic int tag_w(int aw, int lw, int nl);
    return aw - offset_w(lw) - index_w(nl) - 2;
  endfunction

  localparam int OFFSET_W = offset_w(DEF_LINE_WORDS);
  localparam int INDEX_W  = index_w(DEF_NUM_LINES);
  localparam int TAG_W    = tag_w(DEF_ADDR_W, DEF_LINE_WORDS,
                                  DEF_NUM_LINES);

  function automatic logic [63:0] addr_field(
    logic [63:0] a, int lsb, int w);
    return (a >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_offset(
    logic [63:0] a, int lw);
    return addr_field(a, 2, offset_w(lw));
  endfunction

  function automatic logic [63:0] get_index(
    logic [63:0] a, int lw, int nl);
    return addr_field(a, 2 + offset_w(lw), index_w(nl));
  endfunction

  // Tag is everything above the index, so no mask is needed.
  function automatic logic [63:0] get_tag(
    logic [63:0] a, int lw, int nl);
    return a >> (2 + offset_w(lw) + index_w(nl));
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: main-memory word port, one word per req/ready handshake.
// master = cache controller, slave = memory.
interface dcache_if #(
  parameter int ADDR_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              m_ready;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage, combinational read port and one
// synchronous write port (word write plus optional tag/valid write).
module dcache_array #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  parameter int TAG_W      = 22
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_LINES)-1:0]  rd_index,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_offset,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_word,
  input  logic                          we_word,
  input  logic                          we_tag,
  input  logic [$clog2(NUM_LINES)-1:0]  wr_index,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_offset,
  input  logic [31:0]                   wr_word,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic                          wr_valid
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES*LINE_WORDS];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_word  = data[{rd_index, rd_offset}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (we_tag) valid[wr_index] <= wr_valid;
  end

  always_ff @(posedge clk) begin
    if (we_tag) tags[wr_index] <= wr_tag;
    if (we_word) data[{wr_index, wr_offset}] <= wr_word;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate D-cache.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              cache_done,
  dcache_if.master          mport
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OW = offset_w(LINE_WORDS);
  localparam int IW = index_w(NUM_LINES);
  localparam int TW = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  state_t        state;
  logic [OW-1:0] offset, cnt, wr_offset;
  logic [IW-1:0] index, req_idx, wr_index;
  logic [TW-1:0] tag, req_tag, line_tag, wr_tag;
  logic [31:0]   line_word, wr_word;
  logic          line_valid, hit, load, store;
  logic          we_word, we_tag, wr_valid;

  assign offset = OW'(get_offset(64'(addr), LINE_WORDS));
  assign index  = IW'(get_index(64'(addr), LINE_WORDS, NUM_LINES));
  assign tag    = TW'(get_tag(64'(addr), LINE_WORDS, NUM_LINES));

  assign store = mem_write;
  assign load  = mem_read && !mem_write;
  assign hit   = line_valid && (line_tag == tag);

  dcache_array #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_offset(offset),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_word  (line_word),
    .we_word  (we_word),
    .we_tag   (we_tag),
    .wr_index (wr_index),
    .wr_offset(wr_offset),
    .wr_word  (wr_word),
    .wr_tag   (wr_tag),
    .wr_valid (wr_valid)
  );

  // A miss invalidates the victim first, so a refill cut short by
  // reset never leaves mixed data under the old tag.
  always_comb begin
    we_word   = 1'b0;
    we_tag    = 1'b0;
    wr_index  = index;
    wr_offset = offset;
    wr_word   = write_data;
    wr_tag    = tag;
    wr_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (store) we_word = hit;
        else if (load && !hit) we_tag = 1'b1;
      end
      REFILL: begin
        wr_index  = req_idx;
        wr_offset = cnt;
        wr_word   = mport.m_rdata;
        wr_tag    = req_tag;
        wr_valid  = 1'b1;
        we_word   = mport.m_ready;
        we_tag    = mport.m_ready && (cnt == LAST);
      end
      default: ;
    endcase
  end

  assign cache_done = !rst &&
    ((state == REFILL) || (state == WRITE) ||
     ((state == IDLE) && (store || (load && !hit))));

  assign read_data =
    (load && (((state == IDLE) && hit) || (state == RESP)))
      ? line_word : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      req_idx       <= '0;
      req_tag       <= '0;
      mport.m_req   <= 1'b0;
      mport.m_we    <= 1'b0;
      mport.m_addr  <= '0;
      mport.m_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store) begin
            mport.m_req   <= 1'b1;
            mport.m_we    <= 1'b1;
            mport.m_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mport.m_wdata <= write_data;
            state         <= WRITE;
          end else if (load && !hit) begin
            mport.m_req  <= 1'b1;
            mport.m_we   <= 1'b0;
            mport.m_addr <= {tag, index, {OW{1'b0}}, 2'b00};
            cnt          <= '0;
            req_idx      <= index;
            req_tag      <= tag;
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (mport.m_ready) begin
            cnt <= OW'(cnt + 1'b1);
            if (cnt == LAST) begin
              mport.m_req <= 1'b0;
              state       <= RESP;
            end else begin
              mport.m_addr <=
                {req_tag, req_idx, OW'(cnt + 1'b1), 2'b00};
            end
          end
        end
        WRITE: begin
          if (mport.m_ready) begin
            mport.m_req <= 1'b0;
            mport.m_we  <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && load) begin
      if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed vectors against a word memory that answers
// every second cycle of a request, starting on the first.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        cache_done;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dcache_if #(.ADDR_W(32)) mif ();

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data),
    .cache_done(cache_done),
    .mport     (mif)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic        gap;

  initial gap = 1'b0;
  assign mif.m_ready = mif.m_req && !gap;
  always_comb mif.m_rdata = mem[mif.m_addr[13:2]];

  always @(posedge clk) begin
    gap <= mif.m_req && !gap;
    if (mif.m_req && mif.m_we && mif.m_ready)
      mem[mif.m_addr[13:2]] <= mif.m_wdata;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] aq [$];
  logic        wq [$];
  logic [31:0] dq [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int stall, output logic [31:0] rdv);
    bit done;
    done = 0;
    stall = 0;
    rdv = 32'hx;
    aq.delete();
    wq.delete();
    dq.delete();
    mem_read = rd;
    mem_write = wr;
    addr = a;
    write_data = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mif.m_req && mif.m_ready) begin
        aq.push_back(mif.m_addr);
        wq.push_back(mif.m_we);
        dq.push_back(mif.m_wdata);
      end
      if (!cache_done) begin
        rdv = read_data;
        done = 1;
      end else begin
        stall++;
      end
      @(posedge clk);
      #1;
      if (done) break;
    end
    if (!done) chk("timeout", 32'(done), 32'd1);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic acc_chk(input string tag,
                         input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int exp_stall, input logic [31:0] exp_rd,
                         input int exp_n, input logic [31:0] exp_a0);
    int stall;
    logic [31:0] rdv;
    access(rd, wr, a, wd, stall, rdv);
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, "_rdata"}, rdv, exp_rd);
    chk({tag, "_nhs"}, 32'(aq.size()), 32'(exp_n));
    if (exp_n > 0 && aq.size() > 0) begin
      chk({tag, "_addr0"}, aq[0], exp_a0);
      foreach (wq[k]) chk({tag, "_we"}, 32'(wq[k]), 32'(wr));
    end
  endtask

  initial begin
    int hs;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'h11;
    mem[12'h011] = 32'h22;
    mem[12'h012] = 32'h33;
    mem[12'h013] = 32'h44;
    mem[12'h110] = 32'hA0;
    mem[12'h111] = 32'hA1;
    mem[12'h112] = 32'hA2;
    mem[12'h113] = 32'hA3;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    addr = '0;
    write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(cache_done), 32'd0);
    chk("rst_req", 32'(mif.m_req), 32'd0);
    chk("rst_we", 32'(mif.m_we), 32'd0);
    chk("rst_addr", mif.m_addr, 32'd0);
    chk("rst_wdata", mif.m_wdata, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    acc_chk("cold", 1, 0, 32'h40, 0, 8, 32'h11, 4, 32'h40);
    if (aq.size() == 4) begin
      chk("cold_a1", aq[1], 32'h44);
      chk("cold_a2", aq[2], 32'h48);
      chk("cold_a3", aq[3], 32'h4C);
    end
    acc_chk("hit48", 1, 0, 32'h48, 0, 0, 32'h33, 0, 0);
    acc_chk("sthit", 0, 1, 32'h44, 32'hDEADBEEF, 2, 32'h0, 1, 32'h44);
    if (dq.size() == 1) chk("sthit_wd", dq[0], 32'hDEADBEEF);
    acc_chk("hit44", 1, 0, 32'h44, 0, 0, 32'hDEADBEEF, 0, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 32'd2);
    chk("miss_cnt", miss_cnt, 32'd1);
`endif
    acc_chk("stmiss", 0, 1, 32'h1000, 32'h5, 2, 32'h0, 1, 32'h1000);
    acc_chk("ld1000", 1, 0, 32'h1000, 0, 8, 32'h5, 4, 32'h1000);
    acc_chk("conf", 1, 0, 32'h440, 0, 8, 32'hA0, 4, 32'h440);
    acc_chk("evict", 1, 0, 32'h40, 0, 8, 32'h11, 4, 32'h40);

    hs = 0;
    mem_read = 1'b1;
    addr = 32'h440;
    for (int i = 0; i < 50 && hs < 2; i++) begin
      @(negedge clk);
      if (mif.m_req && mif.m_ready) hs++;
    end
    chk("mid_hs", 32'(hs), 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_req", 32'(mif.m_req), 32'd0);
    chk("mid_done", 32'(cache_done), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    acc_chk("reload", 1, 0, 32'h40, 0, 8, 32'h11, 4, 32'h40);
    acc_chk("hit4c", 1, 0, 32'h4C, 0, 0, 32'h44, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller. It is the responder to the MEM stage's load/store requests.
- Produces `cache_done`, which stalls the MEM/WB pipeline register and upstream stages while an access is outstanding.
- Sits between the MEM stage and the main-memory word port; memory is accessed one word per handshake.

Parameters:
- LINE_WORDS, 4, words per cache line (power of 2, ≥2).
- NUM_LINES, 64, number of lines (power of 2).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  MEM stage load request, held for the whole stall.
- mem_write  in  1  MEM stage store request, held for the whole stall.
- addr  in  ADDR_W  byte address; word aligned, low 2 bits ignored.
- write_data  in  32  store data.
- read_data  out  32  load data, valid when mem_read=1 and cache_done=0.
- cache_done  out  1  1 = access in progress, pipeline holds; 0 = MEM stage may advance.
- m_req  out  1  memory word request.
- m_we  out  1  1 = write, 0 = read; valid with m_req.
- m_addr  out  ADDR_W  word-aligned memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid with m_ready.
- m_ready  in  1  memory completes the current request this cycle.

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(NUM_LINES) bits, tag = remainder.
- Storage per line: valid bit, tag, LINE_WORDS×32 data.
- Reset: all valid bits cleared, state IDLE, cache_done=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, read_data=0. The data array is not reset.
- mem_read and mem_write both high is illegal; mem_write takes priority.
- IDLE:
  - Load hit: read_data = line word (combinational from array), cache_done=0, zero-cycle stall.
  - Load miss: cache_done=1 combinationally in the same cycle; go to REFILL with word counter=0.
  - Store: cache_done=1 combinationally; on tag hit, the array word is updated at the clock edge; go to WRITE.
- REFILL:
  - m_req=1, m_we=0, m_addr = {tag,index,counter,2'b00}.
  - On m_ready: write m_rdata into the line at counter, counter++.
  - After the last word: set valid, write tag, go to RESP.
  - cache_done=1 throughout.
- WRITE:
  - m_req=1, m_we=1, m_addr = aligned addr, m_wdata = write_data.
  - On m_ready go to RESP. cache_done=1.
- RESP:
  - cache_done=0 for exactly one cycle; read_data = line word for loads; then IDLE.
  - RESP does not re-evaluate the request, so a held request is consumed exactly once.
- m_req stays high from entering REFILL/WRITE until the final m_ready.
- m_addr and m_we are stable while m_req=1.
- Miss latency: LINE_WORDS memory handshakes plus 1 RESP cycle.
- Store latency: 1 memory handshake plus 1 RESP cycle.
- Counter wraps modulo LINE_WORDS; refill always starts at word 0.
- The request is sampled only in IDLE; changes to addr or data mid-stall are undefined.
- Reset asserted mid-REFILL: the line stays invalid, m_req drops immediately (async), state returns to IDLE.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - Load hit in IDLE: hit_cnt +1.
  - Load miss on entering REFILL: miss_cnt +1.
  - Stores are not counted.
  - Counters saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package dcache_pkg: state enum (IDLE, REFILL, WRITE, RESP), derived widths OFFSET_W/INDEX_W/TAG_W as localparam functions of the parameters, addr-field extraction functions.
- One natural sub-module, dcache_array: valid/tag/data storage with a combinational read port and a single synchronous write port (word write plus optional tag/valid set). It carries no FSM logic.

Test Plan:
- Cold load: reset, mem_read addr=0x40, memory returns 0x11,0x22,0x33,0x44 with m_ready every 2nd cycle → m_addr sequence 0x40,0x44,0x48,0x4C; cache_done=1 for 8 cycles, then 0 in RESP with read_data=0x11.
- Hit after refill: mem_read addr=0x48 next → cache_done never asserted, read_data=0x33, m_req stays 0.
- Store hit: mem_write addr=0x44 data=0xDEADBEEF → one write with m_addr=0x44, m_we=1; subsequent load 0x44 hits with 0xDEADBEEF.
- Store miss: mem_write addr=0x1000 data=0x5 → memory write issued; following load 0x1000 misses and refills (no allocate).
- Conflict: load 0x40, then load 0x40+NUM_LINES×LINE_WORDS×4 → second access misses and evicts; reloading 0x40 misses again.
- Reset mid-refill: assert rst after 2 of 4 words → m_req=0 and cache_done=0 immediately; reload 0x40 performs a full 4-word refill.
